rtc_bcd_timekeeper: RTL and testbench
=====================================

// Module: rtc_bcd_timekeeper
// PURPOSE
// - Avalon-MM slave holding wall-clock time HH:MM:SS as packed BCD.
// - Runs from a prescaled 1 Hz tick and wraps at 24 h.
// - Compares the time against a programmable alarm and raises an IRQ on a match.
// - Upstream of the SSEG_* PIO digit ports: software reads the TIME register or the
//   digit outputs and writes the decoded patterns to the HOUR/MIN/SEC tens/units PIOs.
// PARAMETERS
// - PRESCALE  50_000_000  clk cycles per 1 s tick; minimum 2; the bench uses 4.
// PORTS
// - clk         in   1   system clock; the only clock domain.
// - reset       in   1   synchronous, active-high reset.
// - address     in   3   word address: 0 TIME, 1 ALARM, 2 CTRL, 3 STATUS; 4..7 read as 0.
// - chipselect  in   1   slave select.
// - write_n     in   1   active-low write strobe.
// - writedata   in   32  write data.
// - readdata    out  32  combinational read mux, zero wait states, 0 when unmapped.
// - irq         out  1   level interrupt = STATUS.alarm & CTRL.irq_en.
// - tick_1hz    out  1   one-cycle pulse on each prescaler terminal count.
// - time_bcd    out  24  {Ht,Hu,Mt,Mu,St,Su}, 4 bits each; mirrors TIME.
// BEHAVIOUR
// - A write occurs when chipselect && !write_n. A read is chipselect-independent,
//   as in the PIO slaves.
// - TIME [23:0] RW:
//   - A write loads the time only if legal: each nibble <= 9, Ht <= 2, H <= 23,
//     Mt <= 5, St <= 5.
//   - A legal write also clears the prescaler to 0.
//   - An illegal write leaves TIME unchanged and sets STATUS.set_err.
// - ALARM [23:0] RW plus bit 24 alarm_en RW.
//   - Same legality rule as TIME. An illegal write is ignored and sets set_err.
//   - Bit 24 is written only when the whole word is legal.
// - CTRL: bit0 run, bit1 irq_en; both RW. Other bits read 0.
// - STATUS: bit0 alarm, bit1 set_err. Write-1-to-clear; writing 0 has no effect.
// - Reset values: TIME 0, ALARM 0, alarm_en 0, run 0, irq_en 0, STATUS 0,
//   prescaler 0, tick_1hz 0, irq 0, readdata 0.
// - Prescaler:
//   - While run = 1 it counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and drives
//     tick_1hz = 1 for that cycle.
//   - While run = 0 it holds its value and tick_1hz = 0.
// - Time advance: on a tick cycle TIME increments at that clock edge.
//   - Su 9 -> 0 carries into St. St:Su 59 -> 00 carries into Mu.
//   - Mt:Mu 59 -> 00 carries into Hu. Hu 9 -> 0 carries into Ht, except at 23.
//   - 23:59:59 -> 00:00:00.
// - Alarm match:
//   - Compared on the cycle after a TIME update, whether that update came from a tick
//     or a legal write.
//   - If alarm_en and TIME == ALARM, STATUS.alarm is set.
//   - A match fires once per update, not continuously, while time sits equal.
// - Simultaneous events:
//   - A legal TIME write in a tick cycle wins: the written value loads, the tick's
//     increment is discarded, and the prescaler is cleared.
//   - A W1C of alarm in the same cycle as a new match: set wins.
//   - A W1C of set_err in the same cycle as an illegal write: set wins.
// - readdata reflects register state in the same cycle. A read-after-write in the
//   next cycle returns the new value.
// - Reset mid-count: all state returns to reset values on the next edge; any pending
//   match is dropped.
// STRUCTURE
// - Package rtc_pkg:
//   - address localparams ADDR_TIME/ALARM/CTRL/STATUS.
//   - bit-position localparams RUN_BIT, IRQEN_BIT, ALARM_BIT, SETERR_BIT, ALEN_BIT.
//   - function bcd_time_legal(logic [23:0]).
//   - packed struct bcd_time_t {Ht,Hu,Mt,Mu,St,Su}.
// - Sub-module rtc_bcd_digit_pair: tens/units counter with tens/units limit inputs,
//   carry-in, carry-out and load. Instantiated for SS, MM and HH; the HH instance
//   applies the 23 wrap through its limit inputs.
// - Top level holds the prescaler, registers, W1C logic, match detect and read mux.
// TESTING (PRESCALE=4)
// 1. Reset, then write CTRL=1 and let 240 cycles pass -> TIME=0x000100, 60 tick_1hz
//    pulses each 1 cycle wide and 4 cycles apart.
// 2. Write TIME=0x235958 with run=1, wait 2 ticks -> 0x235959 then 0x000000.
//    Also check 0x095959 -> 0x100000 and 0x195959 -> 0x200000.
// 3. Write TIME=0x246000 -> TIME unchanged and STATUS=0x2.
//    Then write STATUS=0x2 -> STATUS=0x0.
//    Then write ALARM=0x01_0A0000 -> ALARM unchanged, alarm_en still 0, STATUS=0x2.
// 4. Write ALARM=0x01_120001 (en=1), CTRL=3, TIME=0x120000; after 1 tick ->
//    STATUS.alarm=1, irq=1.
//    Write STATUS=0x1 -> irq=0 next cycle and stays 0 on later ticks.
// 5. Legal TIME write issued on the exact tick cycle -> written value held, prescaler
//    at 0, next tick exactly 4 cycles later.
//    W1C of alarm coinciding with a new match -> alarm stays 1.
// 6. Assert reset mid-count with irq=1 -> all outputs and registers 0 on the next edge.
//    Clear CTRL.run for 20 cycles -> TIME frozen and no tick_1hz.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared register map, bit positions and BCD time helpers for the RTC timekeeper.
package rtc_pkg;

  localparam logic [2:0] ADDR_TIME   = 3'd0;
  localparam logic [2:0] ADDR_ALARM  = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  localparam int unsigned RUN_BIT    = 0;
  localparam int unsigned IRQEN_BIT  = 1;
  localparam int unsigned ALARM_BIT  = 0;
  localparam int unsigned SETERR_BIT = 1;
  localparam int unsigned ALEN_BIT   = 24;

  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] hu;
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  // True when the packed value is a valid 24 h wall-clock time.
  function automatic logic bcd_time_legal(logic [23:0] t);
    bcd_time_t b;
    b = bcd_time_t'(t);
    bcd_time_legal = (b.ht <= 4'd2) && (b.hu <= 4'd9) &&
                     !((b.ht == 4'd2) && (b.hu > 4'd3)) &&
                     (b.mt <= 4'd5) && (b.mu <= 4'd9) &&
                     (b.st <= 4'd5) && (b.su <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bcd_digit_pair.sv
// Two-digit BCD counter (tens:units) that wraps to 00 at a programmable limit.
module rtc_bcd_digit_pair (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       carry_i,
  input  logic [3:0] tens_lim_i,
  input  logic [3:0] units_lim_i,
  output logic [7:0] value_o,
  output logic       carry_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       at_lim;

  assign at_lim  = (tens_q == tens_lim_i) && (units_q == units_lim_i);
  assign carry_o = carry_i && at_lim;
  assign value_o = {tens_q, units_q};

  // A load always overrides an increment arriving in the same cycle.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load_i) begin
      tens_d  = load_val_i[7:4];
      units_d = load_val_i[3:0];
    end else if (carry_i) begin
      if (at_lim) begin
        tens_d  = 4'd0;
        units_d = 4'd0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/rtc_bcd_timekeeper.sv
// Avalon-MM real-time clock: BCD HH:MM:SS timekeeping from a prescaled 1 Hz tick,
// with a programmable alarm that raises a level interrupt.
module rtc_bcd_timekeeper
  import rtc_pkg::*;
#(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        tick_1hz,
  output logic [23:0] time_bcd
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q;
  logic            run_q, irq_en_q;
  logic [23:0]     alarm_q;
  logic            alen_q;
  logic            st_alarm_q, st_alarm_d;
  logic            st_seterr_q, st_seterr_d;
  logic            upd_q;

  logic        wr_en, wr_time, wr_alarm, wr_ctrl, wr_status;
  logic        wr_legal, time_load, alarm_load, set_err_set;
  logic        tick, match;
  logic        ss_carry, mm_carry, hh_carry;
  logic [7:0]  ss_val, mm_val, hh_val;
  logic [23:0] time_q;
  logic        unused_wdata;

  assign unused_wdata = ^{writedata[31:25], hh_carry};

  assign wr_en       = chipselect && !write_n;
  assign wr_time     = wr_en && (address == ADDR_TIME);
  assign wr_alarm    = wr_en && (address == ADDR_ALARM);
  assign wr_ctrl     = wr_en && (address == ADDR_CTRL);
  assign wr_status   = wr_en && (address == ADDR_STATUS);
  assign wr_legal    = bcd_time_legal(writedata[23:0]);
  assign time_load   = wr_time && wr_legal;
  assign alarm_load  = wr_alarm && wr_legal;
  assign set_err_set = (wr_time || wr_alarm) && !wr_legal;

  assign tick = run_q && (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (time_load || tick) begin
      cnt_q <= '0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  rtc_bcd_digit_pair u_ss (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (time_load),
    .load_val_i  (writedata[7:0]),
    .carry_i     (tick),
    .tens_lim_i  (4'd5),
    .units_lim_i (4'd9),
    .value_o     (ss_val),
    .carry_o     (ss_carry)
  );

  rtc_bcd_digit_pair u_mm (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (time_load),
    .load_val_i  (writedata[15:8]),
    .carry_i     (ss_carry),
    .tens_lim_i  (4'd5),
    .units_lim_i (4'd9),
    .value_o     (mm_val),
    .carry_o     (mm_carry)
  );

  // Hours wrap at 23 rather than 59.
  rtc_bcd_digit_pair u_hh (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (time_load),
    .load_val_i  (writedata[23:16]),
    .carry_i     (mm_carry),
    .tens_lim_i  (4'd2),
    .units_lim_i (4'd3),
    .value_o     (hh_val),
    .carry_o     (hh_carry)
  );

  assign time_q = {hh_val, mm_val, ss_val};

  // Match is evaluated one cycle after any TIME update, so it fires once per update.
  assign match = upd_q && alen_q && (time_q == alarm_q);

  always_comb begin
    st_alarm_d  = match || (st_alarm_q && !(wr_status && writedata[ALARM_BIT]));
    st_seterr_d = set_err_set || (st_seterr_q && !(wr_status && writedata[SETERR_BIT]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      alarm_q     <= '0;
      alen_q      <= 1'b0;
      st_alarm_q  <= 1'b0;
      st_seterr_q <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        run_q    <= writedata[RUN_BIT];
        irq_en_q <= writedata[IRQEN_BIT];
      end
      if (alarm_load) begin
        alarm_q <= writedata[23:0];
        alen_q  <= writedata[ALEN_BIT];
      end
      st_alarm_q  <= st_alarm_d;
      st_seterr_q <= st_seterr_d;
      upd_q       <= time_load || tick;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_TIME:   readdata[23:0] = time_q;
      ADDR_ALARM: begin
        readdata[23:0]     = alarm_q;
        readdata[ALEN_BIT] = alen_q;
      end
      ADDR_CTRL: begin
        readdata[RUN_BIT]   = run_q;
        readdata[IRQEN_BIT] = irq_en_q;
      end
      ADDR_STATUS: begin
        readdata[ALARM_BIT]  = st_alarm_q;
        readdata[SETERR_BIT] = st_seterr_q;
      end
      default: readdata = '0;
    endcase
  end

  assign irq      = st_alarm_q && irq_en_q;
  assign tick_1hz = tick;
  assign time_bcd = time_q;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Scoreboard bench for rtc_bcd_timekeeper with PRESCALE = 4.
module tb_rtc_bcd_timekeeper;
  import rtc_pkg::*;

  localparam int unsigned PRESCALE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq, tick_1hz;
  logic [23:0] time_bcd;

  rtc_bcd_timekeeper #(.PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .tick_1hz   (tick_1hz),
    .time_bcd   (time_bcd)
  );

  always #5 clk = ~clk;

  typedef enum int {KRd, KIrq, KTick, KBcd, KVal} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    logic [31:0] obs;
    string       name;
  } item_t;

  item_t sb_q[$];
  logic  strobe = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    tick_cnt = 0;
  int    last_tick = -1;
  int    min_gap = 1000;
  int    max_gap = 0;

  // Monitor: tick statistics every cycle, scoreboard pop whenever a check is presented.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    int          gap;
    cyc++;
    if (tick_1hz === 1'b1) begin
      tick_cnt++;
      if (last_tick >= 0) begin
        gap = cyc - last_tick;
        if (gap < min_gap) min_gap = gap;
        if (gap > max_gap) max_gap = gap;
      end
      last_tick = cyc;
    end
    if (strobe) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: got a check with no expected entry");
      end else begin
        it = sb_q.pop_front();
        case (it.kind)
          KRd:     act = readdata;
          KIrq:    act = {31'd0, irq};
          KTick:   act = {31'd0, tick_1hz};
          KBcd:    act = {8'd0, time_bcd};
          default: act = it.obs;
        endcase
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input kind_e k, input logic [2:0] a, input logic [31:0] e,
                     input logic [31:0] o, input string nm);
    item_t it;
    it.kind = k;
    it.exp  = e;
    it.obs  = o;
    it.name = nm;
    sb_q.push_back(it);
    address = a;
    strobe  = 1'b1;
    @(negedge clk);
    #1;
    strobe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    chk(KRd, a, e, 32'd0, nm);
  endtask

  task automatic chk_val(input int o, input int e, input string nm);
    chk(KVal, 3'd0, 32'(e), 32'(o), nm);
  endtask

  // Returns in the cycle just after the tick edge.
  task automatic wait_tick(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * PRESCALE + 4; i++) begin
      @(negedge clk);
      if (tick_1hz === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no tick_1hz within budget, expected one", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_on_tick(input logic [2:0] a, input logic [31:0] d);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * PRESCALE + 4; i++) begin
      @(negedge clk);
      if (tick_1hz === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_on_tick: no tick_1hz within budget, expected one");
    end
    bus_wr(a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1. Reset state, then free-run for 240 cycles.
    chk_rd(ADDR_TIME, 32'h0, "rst_time");
    chk_rd(ADDR_ALARM, 32'h0, "rst_alarm");
    chk_rd(ADDR_CTRL, 32'h0, "rst_ctrl");
    chk_rd(ADDR_STATUS, 32'h0, "rst_status");
    chk(KIrq, 3'd0, 32'h0, 32'h0, "rst_irq");
    chk(KTick, 3'd0, 32'h0, 32'h0, "rst_tick");
    chk(KBcd, 3'd0, 32'h0, 32'h0, "rst_time_bcd");

    tick_cnt  = 0;
    last_tick = -1;
    min_gap   = 1000;
    max_gap   = 0;
    bus_wr(ADDR_CTRL, 32'h1);
    repeat (239) @(posedge clk);
    #1;
    bus_wr(ADDR_CTRL, 32'h0);
    chk_rd(ADDR_TIME, 32'h0000_0100, "run240_time");
    chk_val(tick_cnt, 60, "run240_ticks");
    chk_val(min_gap, 4, "tick_min_gap");
    chk_val(max_gap, 4, "tick_max_gap");
    chk(KBcd, 3'd0, 32'h0000_0100, 32'h0, "run240_time_bcd");

    // 2. Carry chains and midnight wrap.
    bus_wr(ADDR_CTRL, 32'h1);
    bus_wr(ADDR_TIME, 32'h0023_5958);
    wait_tick("wrap_t1");
    chk_rd(ADDR_TIME, 32'h0023_5959, "time_235959");
    wait_tick("wrap_t2");
    chk_rd(ADDR_TIME, 32'h0000_0000, "time_midnight");
    bus_wr(ADDR_TIME, 32'h0009_5959);
    wait_tick("hu_carry");
    chk_rd(ADDR_TIME, 32'h0010_0000, "time_100000");
    bus_wr(ADDR_TIME, 32'h0019_5959);
    wait_tick("hu_carry2");
    chk(KBcd, 3'd0, 32'h0020_0000, 32'h0, "time_bcd_200000");
    bus_wr(ADDR_CTRL, 32'h0);

    // 3. Illegal writes and set_err W1C.
    bus_wr(ADDR_TIME, 32'h0024_6000);
    chk_rd(ADDR_TIME, 32'h0020_0000, "bad_time_kept");
    chk_rd(ADDR_STATUS, 32'h2, "bad_time_seterr");
    bus_wr(ADDR_STATUS, 32'h2);
    chk_rd(ADDR_STATUS, 32'h0, "seterr_w1c");
    bus_wr(ADDR_ALARM, 32'h010A_0000);
    chk_rd(ADDR_ALARM, 32'h0, "bad_alarm_kept");
    chk_rd(ADDR_STATUS, 32'h2, "bad_alarm_seterr");
    bus_wr(ADDR_STATUS, 32'h2);

    // 4. Alarm match raises irq; W1C clears it and later ticks do not re-fire.
    bus_wr(ADDR_ALARM, 32'h0112_0001);
    chk_rd(ADDR_ALARM, 32'h0112_0001, "alarm_readback");
    bus_wr(ADDR_CTRL, 32'h3);
    bus_wr(ADDR_TIME, 32'h0012_0000);
    wait_tick("alarm_tick");
    @(posedge clk);
    #1;
    chk_rd(ADDR_STATUS, 32'h1, "alarm_status");
    chk(KIrq, 3'd0, 32'h1, 32'h0, "alarm_irq");
    bus_wr(ADDR_STATUS, 32'h1);
    chk(KIrq, 3'd0, 32'h0, 32'h0, "irq_cleared");
    chk_rd(ADDR_STATUS, 32'h0, "status_cleared");
    wait_tick("post_clear1");
    chk(KIrq, 3'd0, 32'h0, 32'h0, "irq_stays0_a");
    wait_tick("post_clear2");
    chk(KIrq, 3'd0, 32'h0, 32'h0, "irq_stays0_b");

    // 5. TIME write on a tick cycle, then W1C colliding with a fresh match.
    wr_on_tick(ADDR_TIME, 32'h0012_0000);
    chk_rd(ADDR_TIME, 32'h0012_0000, "tickwr_time");
    n = 1;
    for (int i = 0; i < 4 * PRESCALE; i++) begin
      @(negedge clk);
      n++;
      if (tick_1hz === 1'b1) break;
    end
    @(posedge clk);
    #1;
    bus_wr(ADDR_STATUS, 32'h1);
    chk_val(n, 4, "tickwr_gap");
    chk_rd(ADDR_STATUS, 32'h1, "w1c_vs_match");
    chk(KIrq, 3'd0, 32'h1, 32'h0, "w1c_vs_match_irq");

    // 6. Reset while running with irq asserted, then a frozen clock.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk(KIrq, 3'd0, 32'h0, 32'h0, "mid_rst_irq");
    chk_rd(ADDR_TIME, 32'h0, "mid_rst_time");
    chk_rd(ADDR_ALARM, 32'h0, "mid_rst_alarm");
    chk_rd(ADDR_CTRL, 32'h0, "mid_rst_ctrl");
    chk_rd(ADDR_STATUS, 32'h0, "mid_rst_status");
    chk(KBcd, 3'd0, 32'h0, 32'h0, "mid_rst_time_bcd");

    bus_wr(ADDR_TIME, 32'h0012_3456);
    bus_wr(ADDR_CTRL, 32'h2);
    tick_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk_rd(ADDR_TIME, 32'h0012_3456, "frozen_time");
    chk_val(tick_cnt, 0, "frozen_ticks");
    chk_rd(3'd5, 32'h0, "unmapped_read");

    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp += sb_q.size();
      n_bad += sb_q.size();
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
